// File: rtl/fifo_wr_arb_ctrl.sv
// Two-requester write arbiter and pointer/flag controller for an external FIFO memory.
// Round-robin priority flips after each accepted write; the read side is show-ahead.
module fifo_wr_arb_ctrl #(
    parameter int DATA  = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               req0_valid,
    input  logic [DATA-1:0]    req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [DATA-1:0]    req1_data,
    output logic               req1_ready,
    input  logic               rd_en,
    output logic               mem_wclken,
    output logic [PTR_W-2:0]   mem_waddr,
    output logic [DATA-1:0]    mem_wdata,
    output logic [PTR_W-2:0]   mem_raddr,
    output logic               full,
    output logic               empty,
    output logic [PTR_W-1:0]   count,
    output logic               grant_id,
    output logic               rd_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    pri_t             r_state;
    pri_t             w_state_next;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_rd_err;

    logic             w_empty;
    logic             w_full;
    logic             w_grant;
    logic             w_wr_ok;
    logic             w_wr_acc;
    logic             w_pop;
    logic             w_pop_err;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                     (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);

    // Grant: a lone requester wins; contention or silence falls back to the preferred one.
    always_comb begin
        w_grant = (r_state == PRI1);
        if (req0_valid && !req1_valid) begin
            w_grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant = 1'b1;
        end
    end

    // No write is taken while reset is asserted, so the words offered then are dropped.
    assign w_wr_ok    = !w_full && !flush && !rst;
    assign req0_ready = w_wr_ok && !w_grant;
    assign req1_ready = w_wr_ok && w_grant;
    assign w_wr_acc   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_pop      = rd_en && !w_empty && !flush;
    assign w_pop_err  = rd_en && w_empty;

    always_comb begin
        w_state_next = r_state;
        if (w_wr_acc) begin
            w_state_next = w_grant ? PRI0 : PRI1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PRI0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_pop_err) begin
                r_rd_err <= 1'b1;
            end
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
            end
        end
    end

    assign mem_wclken = w_wr_acc;
    assign mem_waddr  = r_wptr[ADDR_W-1:0];
    assign mem_wdata  = w_grant ? req1_data : req0_data;
    assign mem_raddr  = r_rptr[ADDR_W-1:0];
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_wptr - r_rptr;
    assign grant_id   = w_grant;
    assign rd_err     = r_rd_err;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed bench for fifo_wr_arb_ctrl with a behavioural memory behind the write/read ports.
// Inputs change 1ns after a rising edge; outputs are checked 1ns later, well before the next edge.
module tb_fifo_wr_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        rd_en;
    logic        mem_wclken;
    logic [2:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [2:0]  mem_raddr;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        grant_id;
    logic        rd_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] tb_mem [8];
    logic [15:0] rdata;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wclken) begin
            tb_mem[mem_waddr] <= mem_wdata;
        end
    end
    assign rdata = tb_mem[mem_raddr];

    fifo_wr_arb_ctrl #(.DATA(16), .DEPTH(8), .PTR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rd_en      (rd_en),
        .mem_wclken (mem_wclken),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .grant_id   (grant_id),
        .rd_err     (rd_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string what);
        @(posedge clk);
        #1;
        $display("t=%0t %s: count=%0d empty=%0b full=%0b grant=%0b rd_err=%0b",
                 $time, what, count, empty, full, grant_id, rd_err);
    endtask

    task automatic idle();
        rst        = 1'b0;
        flush      = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 16'h0000;
        req1_valid = 1'b0;
        req1_data  = 16'h0000;
        rd_en      = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick("reset");
        tick("reset");
        idle();
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_rdy0", 32'(req0_ready), 32'd1);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_wclken", 32'(mem_wclken), 32'd0);
        chk("rst_rderr", 32'(rd_err), 32'd0);

        // Fill with 0x0001..0x0008 from requester 0.
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            req0_data  = 16'(i + 1);
            #1;
            chk("fill_wclken", 32'(mem_wclken), 32'd1);
            chk("fill_waddr", 32'(mem_waddr), 32'(i));
            chk("fill_wdata", 32'(mem_wdata), 32'(i + 1));
            tick("write req0");
        end
        req0_data = 16'h0009;
        #1;
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd8);
        chk("full_rdy0", 32'(req0_ready), 32'd0);
        chk("full_wclken", 32'(mem_wclken), 32'd0);

        // Pop while full with a pending write: no bypass.
        rd_en = 1'b1;
        #1;
        chk("nobypass_rdy0", 32'(req0_ready), 32'd0);
        chk("nobypass_wclken", 32'(mem_wclken), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) req0_valid = 1'b0;
            #1;
            chk("drain_raddr", 32'(mem_raddr), 32'(i));
            chk("drain_rdata", 32'(rdata), 32'(i + 1));
            tick("pop");
            if (i == 0) begin
                chk("slot_free_rdy0", 32'(req0_ready), 32'd1);
            end
        end
        rd_en = 1'b0;
        #1;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        chk("wrap_raddr", 32'(mem_raddr), 32'd0);
        chk("wrap_waddr", 32'(mem_waddr), 32'd0);

        // Pop on empty: ignored, sticky error.
        rd_en = 1'b1;
        tick("pop empty");
        rd_en = 1'b0;
        #1;
        chk("underflow_err", 32'(rd_err), 32'd1);
        chk("underflow_count", 32'(count), 32'd0);
        chk("underflow_raddr", 32'(mem_raddr), 32'd0);
        tick("idle");
        tick("idle");
        chk("underflow_sticky", 32'(rd_err), 32'd1);

        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
        #1;
        chk("rst_clears_err", 32'(rd_err), 32'd0);

        // Both requesters streaming with continuous pops: A,B,A,B...
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rd_en      = 1'b1;
        for (int n = 0; n < 8; n++) begin
            req0_data = 16'hA000 + 16'(n);
            req1_data = 16'hB000 + 16'(n);
            #1;
            chk("rr_grant", 32'(grant_id), 32'(n % 2));
            chk("rr_rdy0", 32'(req0_ready), 32'((n % 2) == 0));
            chk("rr_wdata", 32'(mem_wdata), (n % 2) ? 32'hB000 + 32'(n) : 32'hA000 + 32'(n));
            chk("rr_count", 32'(count), (n == 0) ? 32'd0 : 32'd1);
            if (n > 0) begin
                chk("rr_rdata", 32'(rdata),
                    ((n - 1) % 2) ? 32'hB000 + 32'(n - 1) : 32'hA000 + 32'(n - 1));
            end
            tick("arb write+pop");
            if (n == 0) begin
                chk("wr_pop_empty_err", 32'(rd_err), 32'd1);
                chk("wr_pop_empty_cnt", 32'(count), 32'd1);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rr_last_rdata", 32'(rdata), 32'hB007);
        tick("pop");
        rd_en = 1'b0;
        #1;
        chk("rr_empty", 32'(empty), 32'd1);

        // Five writes from requester 0, then flush while requester 1 offers a word.
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_data = 16'h5000 + 16'(i);
            tick("write req0");
        end
        req0_valid = 1'b0;
        #1;
        chk("pre_flush_count", 32'(count), 32'd5);
        flush      = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 16'hBEEF;
        #1;
        chk("flush_rdy1", 32'(req1_ready), 32'd0);
        chk("flush_wclken", 32'(mem_wclken), 32'd0);
        tick("flush");
        flush      = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_state", 32'(grant_id), 32'd1);
        chk("flush_keeps_err", 32'(rd_err), 32'd1);

        // Three words stored, then reset with traffic on both sides.
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_data = 16'h3000 + 16'(i);
            tick("write req0");
        end
        #1;
        chk("pre_rst_count", 32'(count), 32'd3);
        rst   = 1'b1;
        rd_en = 1'b1;
        #1;
        chk("rst_cycle_wclken", 32'(mem_wclken), 32'd0);
        tick("reset with traffic");
        idle();
        #1;
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_err", 32'(rd_err), 32'd0);
        chk("post_rst_state", 32'(grant_id), 32'd0);
        chk("post_rst_waddr", 32'(mem_waddr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
